// File: rtl/imem_miss_queue.sv
// Instruction-side miss queue: tracks outstanding line fills by slot/ID, merges
// duplicate misses, optionally prefetches the next line, and forwards fills to the cache.
module imem_miss_queue #(
    parameter int N_MSHR     = 4,
    parameter int PA_WIDTH   = 32,
    parameter int LINE_BYTES = 16,
    parameter int ID_WIDTH   = 4,
    parameter int PREFETCH   = 1,
    localparam int LINE_WIDTH = LINE_BYTES * 8,
    localparam int CNT_W      = $clog2(N_MSHR + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss_valid,
    input  logic [PA_WIDTH-1:0]   i_miss_addr,
    output logic                  o_miss_ready,
    output logic                  o_mem_enable,
    output logic [PA_WIDTH-1:0]   o_mem_addr,
    output logic [ID_WIDTH-1:0]   o_mem_id,
    input  logic                  i_mem_in_use,
    input  logic                  i_mem_enable,
    input  logic [LINE_WIDTH-1:0] i_mem_data,
    input  logic [ID_WIDTH-1:0]   i_mem_id_response,
    output logic                  o_fill_valid,
    output logic [PA_WIDTH-1:0]   o_fill_addr,
    output logic [LINE_WIDTH-1:0] o_fill_data,
    output logic                  o_fill_prefetch,
    output logic                  o_err_spurious,
    output logic [CNT_W-1:0]      o_count
);

    // Slot states:
    //   state     | meaning
    //   S_FREE    | slot unused, available for allocation
    //   S_PENDING | line fill waiting to be accepted by memory
    //   S_ISSUED  | request accepted, waiting for the fill with this slot's ID

    localparam int OFF   = $clog2(LINE_BYTES);
    localparam int LA_W  = PA_WIDTH - OFF;
    localparam int IDX_W = $clog2(N_MSHR);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_PENDING = 2'd1,
        S_ISSUED  = 2'd2
    } slot_t;

    slot_t                 r_state [N_MSHR];
    logic [LA_W-1:0]       r_line  [N_MSHR];
    logic [N_MSHR-1:0]     r_pf;
    logic                  r_hold;
    logic [IDX_W-1:0]      r_hold_idx;
    logic                  r_fill_valid;
    logic [PA_WIDTH-1:0]   r_fill_addr;
    logic [LINE_WIDTH-1:0] r_fill_data;
    logic                  r_fill_pf;
    logic                  r_err;

    logic [LA_W-1:0]  w_line;
    logic [LA_W-1:0]  w_line_nx;
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_nx_hit;
    logic             w_free0_ok;
    logic             w_free1_ok;
    logic [IDX_W-1:0] w_free0;
    logic [IDX_W-1:0] w_free1;
    logic             w_dem_ok;
    logic [IDX_W-1:0] w_dem_idx;
    logic             w_pf_ok;
    logic [IDX_W-1:0] w_pf_idx;
    logic             w_rsp_ok;
    logic [IDX_W-1:0] w_rsp_idx;
    logic [CNT_W-1:0] w_count;
    logic             w_hold_keep;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_mem_en;
    logic             w_issue;
    logic             w_ready;
    logic             w_accept;
    logic             w_merge;
    logic             w_alloc;
    logic             w_alloc_pf;
    logic             w_unused;

    assign w_line    = i_miss_addr[PA_WIDTH-1:OFF];
    assign w_line_nx = w_line + LA_W'(1);
    assign w_unused  = ^i_miss_addr[OFF-1:0];

    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_nx_hit   = 1'b0;
        w_free0_ok = 1'b0;
        w_free1_ok = 1'b0;
        w_free0    = '0;
        w_free1    = '0;
        w_dem_ok   = 1'b0;
        w_dem_idx  = '0;
        w_pf_ok    = 1'b0;
        w_pf_idx   = '0;
        w_rsp_ok   = 1'b0;
        w_rsp_idx  = '0;
        w_count    = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            if (r_state[i] != S_FREE) begin
                w_count = w_count + CNT_W'(1);
                if (r_line[i] == w_line) begin
                    w_hit     = 1'b1;
                    w_hit_idx = IDX_W'(i);
                end
                if (r_line[i] == w_line_nx) w_nx_hit = 1'b1;
            end else if (!w_free0_ok) begin
                w_free0_ok = 1'b1;
                w_free0    = IDX_W'(i);
            end else if (!w_free1_ok) begin
                w_free1_ok = 1'b1;
                w_free1    = IDX_W'(i);
            end
            if (r_state[i] == S_PENDING && !r_pf[i] && !w_dem_ok) begin
                w_dem_ok  = 1'b1;
                w_dem_idx = IDX_W'(i);
            end
            if (r_state[i] == S_PENDING && r_pf[i] && !w_pf_ok) begin
                w_pf_ok  = 1'b1;
                w_pf_idx = IDX_W'(i);
            end
            // Out-of-range IDs never match a slot index and fall through as spurious.
            if (i_mem_enable && r_state[i] == S_ISSUED && i_mem_id_response == ID_WIDTH'(i)) begin
                w_rsp_ok  = 1'b1;
                w_rsp_idx = IDX_W'(i);
            end
        end
    end

    // A request held under backpressure stays put unless it is a prefetch and a demand is waiting.
    assign w_hold_keep = r_hold && (r_state[r_hold_idx] == S_PENDING)
                         && !(r_pf[r_hold_idx] && w_dem_ok);
    assign w_sel_idx   = w_hold_keep ? r_hold_idx : (w_dem_ok ? w_dem_idx : w_pf_idx);
    assign w_mem_en    = w_dem_ok || w_pf_ok;
    assign w_issue     = w_mem_en && !i_mem_in_use;

    assign w_ready    = rst && ((i_miss_valid && w_hit) || w_free0_ok);
    assign w_accept   = i_miss_valid && w_ready;
    assign w_merge    = w_accept && w_hit;
    assign w_alloc    = w_accept && !w_hit;
    assign w_alloc_pf = w_alloc && (PREFETCH != 0) && !w_nx_hit && w_free1_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MSHR; i++) begin
                r_state[i] <= S_FREE;
                r_line[i]  <= '0;
            end
            r_pf         <= '0;
            r_hold       <= 1'b0;
            r_hold_idx   <= '0;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_data  <= '0;
            r_fill_pf    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                if (w_rsp_ok && w_rsp_idx == IDX_W'(i)) begin
                    r_state[i] <= S_FREE;
                end else if (w_issue && w_sel_idx == IDX_W'(i)) begin
                    r_state[i] <= S_ISSUED;
                end else if (w_alloc && w_free0 == IDX_W'(i)) begin
                    r_state[i] <= S_PENDING;
                    r_line[i]  <= w_line;
                    r_pf[i]    <= 1'b0;
                end else if (w_alloc_pf && w_free1 == IDX_W'(i)) begin
                    r_state[i] <= S_PENDING;
                    r_line[i]  <= w_line_nx;
                    r_pf[i]    <= 1'b1;
                end
                if (w_merge && w_hit_idx == IDX_W'(i)) r_pf[i] <= 1'b0;
            end
            r_hold       <= w_mem_en && i_mem_in_use;
            r_hold_idx   <= w_sel_idx;
            r_fill_valid <= w_rsp_ok;
            if (w_rsp_ok) begin
                r_fill_addr <= {r_line[w_rsp_idx], {OFF{1'b0}}};
                r_fill_data <= i_mem_data;
                r_fill_pf   <= r_pf[w_rsp_idx];
            end
            r_err <= i_mem_enable && !w_rsp_ok;
        end
    end

    assign o_miss_ready    = w_ready;
    assign o_mem_enable    = w_mem_en;
    assign o_mem_addr      = w_mem_en ? {r_line[w_sel_idx], {OFF{1'b0}}} : '0;
    assign o_mem_id        = w_mem_en ? ID_WIDTH'(w_sel_idx) : '0;
    assign o_fill_valid    = r_fill_valid;
    assign o_fill_addr     = r_fill_addr;
    assign o_fill_data     = r_fill_data;
    assign o_fill_prefetch = r_fill_pf;
    assign o_err_spurious  = r_err;
    assign o_count         = w_count;

endmodule

// File: doc/imem_miss_queue.md
Name: imem_miss_queue

Overview:
- Non-blocking miss-handling queue between the instruction cache and the ID-tagged memory port.
- Tracks up to N_MSHR outstanding line fills and merges duplicate misses to the same line.
- Optionally prefetches the next sequential line.
- Memory returns fills out of order; each fill is matched to its slot by ID and forwarded to the cache refill port.

Parameters:
N_MSHR, 4, number of outstanding-miss slots (>=2)
PA_WIDTH, 32, physical address width
LINE_BYTES, 16, cache line size in bytes (power of two); LINE_WIDTH = LINE_BYTES*8
ID_WIDTH, 4, memory transaction ID width (must be >= clog2(N_MSHR))
PREFETCH, 1, 1 = enable next-line prefetch, 0 = demand only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
i_miss_valid  in  1  cache reports a demand miss
i_miss_addr  in  PA_WIDTH  physical address of the miss
o_miss_ready  out  1  miss accepted this cycle (merged or allocated)
o_mem_enable  out  1  memory request valid
o_mem_addr  out  PA_WIDTH  line-aligned request address
o_mem_id  out  ID_WIDTH  request ID (= slot index)
i_mem_in_use  in  1  memory busy; request not taken this cycle
i_mem_enable  in  1  fill response valid
i_mem_data  in  LINE_WIDTH  fill data
i_mem_id_response  in  ID_WIDTH  ID of the fill
o_fill_valid  out  1  refill to cache valid (1-cycle pulse)
o_fill_addr  out  PA_WIDTH  line-aligned refill address
o_fill_data  out  LINE_WIDTH  refill data
o_fill_prefetch  out  1  refill came from an unpromoted prefetch
o_err_spurious  out  1  1-cycle pulse: response ID not ISSUED
o_count  out  clog2(N_MSHR+1)  occupied slots

Behaviour:
- Line address L = addr >> clog2(LINE_BYTES). All emitted addresses are line-aligned (low bits 0).
- Each slot is FREE, PENDING or ISSUED and holds a line address and a prefetch flag.
- Reset (rst low, asynchronous): all slots FREE; every output 0. Responses arriving after reset hit FREE slots and pulse o_err_spurious.
- o_miss_ready is combinational from registered state:
  - 1 if i_miss_valid and L matches any non-FREE slot (merge);
  - else 1 if any slot is FREE;
  - else 0 (full).
- Merge:
  - No new slot is allocated.
  - If the matching slot is a prefetch, its flag is cleared (promoted to demand).
- Allocate: lowest-index FREE slot becomes PENDING with prefetch=0.
- Prefetch, only when PREFETCH=1 on a demand allocation:
  - If line L+1 (mod 2^(PA_WIDTH-clog2(LINE_BYTES)), so it wraps to 0) matches no slot and a second FREE slot exists, the next-lowest FREE slot becomes PENDING with prefetch=1 in the same cycle.
  - Otherwise the prefetch is silently dropped.
- Issue:
  - o_mem_enable=1 while any slot is PENDING.
  - Selection: lowest-index PENDING demand slot first, else lowest-index PENDING prefetch slot.
  - The selection is combinational and stable while held.
  - Accepted on a clock edge with o_mem_enable=1 and i_mem_in_use=0; the slot becomes ISSUED.
  - While i_mem_in_use=1 the request is held, but a newly allocated demand slot may pre-empt a held prefetch selection.
- Response:
  - On i_mem_enable with an ID that indexes an ISSUED slot, o_fill_* is registered the next cycle (latency 1). o_fill_prefetch equals the slot flag at the response edge. The slot becomes FREE at the same edge.
  - An ID that is out of range or indexes a non-ISSUED slot drops the data and pulses o_err_spurious the next cycle.
- Simultaneous events:
  - Allocation and the ready decision use pre-edge state. A slot freed by this cycle's response is not reusable until the next cycle.
  - A miss matching a slot whose response arrives the same cycle merges; the fill covers it.
  - Allocate, issue and response may all occur in one cycle on different slots.
- o_count reflects post-edge occupancy and never exceeds N_MSHR.

Test Plan:
1. Reset: drive rst=0 mid-traffic with 3 slots ISSUED -> all outputs 0 and o_count=0 immediately. A later response ID 1 -> o_err_spurious pulse, no fill.
2. Single miss with PREFETCH=1: addr 0x1004 -> slot0 demand 0x1000 and slot1 prefetch 0x1010. Issue order ID0 then ID1. Response ID1 data 0xAA.. -> fill 0x1010 with prefetch=1 one cycle later.
3. Merge and promotion: while slot1 (0x1010) is pending, miss 0x1018 -> ready=1, o_count unchanged. Fill of 0x1010 -> o_fill_prefetch=0.
4. Full: N_MSHR=4 slots occupied, miss to a new line 0x8000 -> o_miss_ready=0. Response frees slot2 at edge t -> miss accepted at t+1, not at t.
5. Out-of-order responses and backpressure: 4 demands with i_mem_in_use=1 for 5 cycles -> o_mem_addr held stable. Responses in order IDs 3,0,2,1 -> fills in that order with matching addresses.
6. Wrap-around: miss at the top line (0xFFFFFFF0 with PA_WIDTH=32) -> prefetch line 0x00000000.
